// File: rtl/mux2_store_arbiter_pkg.sv
// Shared constants and grant rule for the mux2_store_arbiter block.
// Source encoding is used for ws, q_src and last_grant alike.
package mux2_store_arbiter_pkg;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // Select for this cycle: lone requester wins, ties follow lock or round-robin,
  // and with nobody valid the select parks on the last grantee.
  function automatic logic pick_grant(input logic a_valid, input logic b_valid,
                                      input logic lock, input logic last_grant);
    logic w_sel;
    w_sel = last_grant;
    if (a_valid && !b_valid) begin
      w_sel = SRC_A;
    end else if (b_valid && !a_valid) begin
      w_sel = SRC_B;
    end else if (a_valid && b_valid) begin
      w_sel = lock ? last_grant : ~last_grant;
    end
    return w_sel;
  endfunction

endpackage

// File: rtl/mux2_store_reg.sv
// Behavioural 74LS298 equivalent: 2-input mux with a storage register,
// loads the selected word when load is high, otherwise holds.
module mux2_store_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= sel ? b : a;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mux2_store_arbiter.sv
// Round-robin arbiter sharing one mux-with-storage register between requesters
// A and B, presenting the stored word downstream with valid/ready.
module mux2_store_arbiter
  import mux2_store_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  input  logic             lock,
  output logic             ws,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data,
  output logic             q_src,
  input  logic             q_ready
);

  logic r_last_grant;
  logic r_q_valid;
  logic r_q_src;

  logic w_ws;
  logic w_can_load;
  logic w_accept;

  // NOTE: combinational blocks assign a default first so no path can infer a latch.
  always_comb begin
    w_ws = r_last_grant;
    w_ws = pick_grant(a_valid, b_valid, lock, r_last_grant);
  end

  // Single-entry output register: a drain and a load may share one edge.
  assign w_can_load = ~r_q_valid | q_ready;
  assign a_ready    = w_can_load & (w_ws == SRC_A);
  assign b_ready    = w_can_load & (w_ws == SRC_B);
  assign w_accept   = (a_valid & a_ready) | (b_valid & b_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_valid    <= 1'b0;
      r_q_src      <= SRC_A;
      r_last_grant <= SRC_B;
    end else if (w_accept) begin
      r_q_valid    <= 1'b1;
      r_q_src      <= w_ws;
      r_last_grant <= w_ws;
    end else if (r_q_valid && q_ready) begin
      r_q_valid    <= 1'b0;
    end
  end

  mux2_store_reg #(
    .WIDTH(WIDTH)
  ) u_store (
    .clk  (clk),
    .rst_n(rst_n),
    .sel  (w_ws),
    .load (w_accept),
    .a    (a_data),
    .b    (b_data),
    .q    (q_data)
  );

  assign ws      = w_ws;
  assign q_valid = r_q_valid;
  assign q_src   = r_q_src;

endmodule
